// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int unsigned SUB_MAX_WIDTH = 64;

  // Bit counter width; must hold WIDTH-1.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: x - y - bin.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow-out of one bit position
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = cnt_w(WIDTH);

  sub_state_t       state_q, state_n;
  logic [WIDTH-1:0] sa_q, sa_n;
  logic [WIDTH-1:0] sb_q, sb_n;
  logic [WIDTH-1:0] sr_q, sr_n;
  logic             bq_q, bq_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] diff_q, diff_n;
  logic             bo_q, bo_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             cell_d, cell_b;
  logic             accept;

  full_subtractor u_fs (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (bq_q),
    .d    (cell_d),
    .bout (cell_b)
  );

  // Next-state, datapath and output decode
  always_comb begin
    state_n = state_q;
    sa_n    = sa_q;
    sb_n    = sb_q;
    sr_n    = sr_q;
    bq_n    = bq_q;
    cnt_n   = cnt_q;
    diff_n  = diff_q;
    bo_n    = bo_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        sr_n = {cell_d, sr_q[WIDTH-1:1]};
        sa_n = sa_q >> 1;
        sb_n = sb_q >> 1;
        bq_n = cell_b;
        if (cnt_q == '0) begin
          diff_n  = {cell_d, sr_q[WIDTH-1:1]};
          bo_n    = cell_b;
          state_n = DONE;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      DONE: begin
        // Back-to-back: a request in the done cycle starts a new operation
        if (start) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (accept) begin
      sa_n  = a;
      sb_n  = b;
      sr_n  = '0;
      bq_n  = 1'b0;
      cnt_n = CW'(WIDTH - 1);
    end

    busy_n = (state_n == SHIFT);
    done_n = (state_n == DONE);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      bq_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      sa_q    <= sa_n;
      sb_q    <= sb_n;
      sr_q    <= sr_n;
      bq_q    <= bq_n;
      cnt_q   <= cnt_n;
      diff_q  <= diff_n;
      bo_q    <= bo_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 directed, WIDTH=4 exhaustive).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;

  logic         start4;
  logic [3:0]   a4, b4;
  logic         busy4, done4, bo4;
  logic [3:0]   diff4;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
  );

  // Timeline model: phase 0 = idle, 1..W = busy cycles, W+1 = done cycle
  int           m_ph = 0;
  logic [W:0]   m_pend = '0;
  logic [W-1:0] m_diff = '0;
  logic         m_bo = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph   = 0;
      m_diff = '0;
      m_bo   = 1'b0;
    end else if ((m_ph == 0 || m_ph == W + 1) && start) begin
      m_ph   = 1;
      m_pend = {1'b0, a} - {1'b0, b};
    end else if (m_ph == W + 1) begin
      m_ph = 0;
    end else if (m_ph > 0) begin
      m_ph = m_ph + 1;
      if (m_ph == W + 1) begin
        m_diff = m_pend[W-1:0];
        m_bo   = m_pend[W];
      end
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [W+2:0] got, exp;
    if (chk_en) begin
      got = {busy, done, borrow_out, diff};
      exp = {(m_ph >= 1 && m_ph <= W), (m_ph == W + 1), m_bo, m_diff};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL model_cycle t=%0t busy/done/bo/diff got=%h exp=%h", $time, got, exp);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Issue one WIDTH=8 operation; returns cycles from accept edge to done
  task automatic op8(input logic [7:0] x, input logic [7:0] y, output int lat);
    @(negedge clk);
    start = 1'b1; a = x; b = y;
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) start = 1'b0;
      lat++;
    end while (!done && lat < 30);
    if (!done) begin
      failures++;
      $display("FAIL op8_timeout lat=%0d", lat);
    end
  endtask

  task automatic op4(input logic [3:0] x, input logic [3:0] y);
    int n;
    logic [4:0] e;
    @(negedge clk);
    start4 = 1'b1; a4 = x; b4 = y;
    n = 0;
    do begin
      @(negedge clk);
      start4 = 1'b0;
      n++;
    end while (!done4 && n < 20);
    e = {1'b0, x} - {1'b0, y};
    check($sformatf("exh4 a=%0h b=%0h lat", x, y), 64'(n), 64'd5);
    check($sformatf("exh4 a=%0h b=%0h res", x, y), 64'({bo4, diff4}), 64'(e));
  endtask

  initial begin
    int lat, n, dones;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({busy, done, borrow_out, diff}), 64'd0);
    check("reset_outputs4", 64'({busy4, done4, bo4, diff4}), 64'd0);
    // Simultaneous rst and start: rst wins
    start = 1'b1; a = 8'h11; b = 8'h22;
    @(negedge clk);
    check("rst_beats_start", 64'({busy, done}), 64'd0);
    start = 1'b0;
    rst = 1'b0;
    chk_en = 1'b1;

    // Basic subtraction
    op8(8'h5A, 8'h23, lat);
    check("basic_latency", 64'(lat), 64'd9);
    check("basic_diff", 64'(diff), 64'h37);
    check("basic_borrow", 64'(borrow_out), 64'd0);
    repeat (3) @(negedge clk);

    // Wrap-around cases
    op8(8'h00, 8'h01, lat);
    check("wrap_diff", 64'(diff), 64'hFF);
    check("wrap_borrow", 64'(borrow_out), 64'd1);
    op8(8'hFF, 8'hFF, lat);
    check("equal_diff", 64'(diff), 64'h00);
    check("equal_borrow", 64'(borrow_out), 64'd0);

    // Start while busy is ignored
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h23;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h02;
    @(negedge clk);
    start = 1'b0;
    n = 4;
    while (!done && n < 30) begin @(negedge clk); n++; end
    check("busy_start_latency", 64'(n), 64'd9);
    check("busy_start_diff", 64'({borrow_out, diff}), 64'h037);
    dones = 0;
    repeat (12) begin @(negedge clk); if (done) dones++; end
    check("busy_start_no_extra_done", 64'(dones), 64'd0);

    // Reset mid-operation
    @(negedge clk);
    start = 1'b1; a = 8'hC3; b = 8'h41;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_outputs", 64'({busy, done, borrow_out, diff}), 64'd0);
    dones = 0;
    repeat (12) begin @(negedge clk); if (done) dones++; end
    check("midrst_no_done", 64'(dones), 64'd0);
    op8(8'd10, 8'd3, lat);
    check("after_rst_diff", 64'(diff), 64'd7);

    // Back-to-back: start held through the done cycle
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h34;
    n = 0;
    dones = 0;
    while (n < 25) begin
      @(negedge clk);
      n++;
      if (done) begin
        dones++;
        if (dones == 1) begin
          check("b2b_first_at", 64'(n), 64'd9);
          check("b2b_first_res", 64'({borrow_out, diff}), 64'h1DE);
          a = 8'h80; b = 8'h01;
        end else begin
          check("b2b_second_at", 64'(n), 64'd18);
          check("b2b_second_res", 64'({borrow_out, diff}), 64'h07F);
        end
      end
      if (n == 10) begin
        start = 1'b0;
        check("b2b_no_gap_busy", 64'(busy), 64'd1);
      end
      if (n == 14) check("b2b_hold_diff", 64'({borrow_out, diff}), 64'h1DE);
    end
    check("b2b_done_count", 64'(dones), 64'd2);

    // Exhaustive WIDTH=4
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        op4(4'(i), 4'(j));

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the subtraction counterpart to the team's adder cells. It serves area-constrained datapaths that can tolerate WIDTH-cycle latency, with a start/busy/done handshake toward the controlling FSM.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..64.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  WIDTH  minuend; captured in the cycle `start` is accepted.
- `b`  in  WIDTH  subtrahend; captured with `a`.
- `busy`  out  1  high while the block is in SHIFT.
- `done`  out  1  single-cycle pulse; result valid.
- `diff`  out  WIDTH  `(a - b) mod 2^WIDTH`; registered.
- `borrow_out`  out  1  final borrow; 1 iff `a < b` (unsigned); registered.

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - `start`=1 loads `a` and `b` into shift registers `sa` and `sb`, clears the borrow flop and the result register `sr`, and loads the bit counter with WIDTH-1.
  - Next state is SHIFT.
  - With `start`=0, the block stays in IDLE.
- **SHIFT, each cycle:**
  - The cell computes `d = sa[0]^sb[0]^bq` and `bn = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&bq)`.
  - `sr` shifts right with `d` entering at the MSB; `sa` and `sb` shift right; `bq <= bn`.
  - When the counter is 0, the block copies the final `{bn, shifted sr}` into `{borrow_out, diff}` and goes to DONE. Otherwise the counter decrements.
- **DONE:** lasts one cycle; `done`=1.
  - `start`=1 here is accepted exactly as in IDLE (back-to-back operation) and the next state is SHIFT.
  - Otherwise the next state is IDLE.
- **Ignored input:** `start` in SHIFT is ignored. It is not queued, and the operands are not re-sampled.
- **Result hold:** `diff` and `borrow_out` hold their value from completion until the next completion or reset. They do not change during a later SHIFT.
- **Arithmetic:** modular, unsigned. Signed interpretation is left to the consumer: for signed operands, `diff` is the correct two's-complement result when no overflow occurs.

## Timing
- **Reset values:** state IDLE; `busy`=0, `done`=0, `diff`=0, `borrow_out`=0; internal registers cleared.
- **Latency:** `start` is accepted at edge E0. `busy`=1 for cycles E0+1 .. E0+WIDTH, and `done`=1 in cycle E0+WIDTH+1 with `diff`/`borrow_out` already valid in that cycle.
- **Throughput:** back-to-back, one result every WIDTH+1 cycles.
- **`busy`/`done`:** never both high; both are derived from state registers (no combinational path from inputs).
- **Reset mid-operation:** `rst` in any state takes effect at the next edge. The current operation is abandoned, all outputs return to reset values, and no `done` pulse is issued.
- **Simultaneous `rst` and `start`:** `rst` wins; the block stays in IDLE.

## Structure
- **Package `serial_sub_pkg`:**
  - state enum `sub_state_t` {IDLE, SHIFT, DONE}
  - constant `SUB_MAX_WIDTH`=64
  - counter-width function `cnt_w(WIDTH)=$clog2(WIDTH)`
- **Sub-module `full_subtractor`:** combinational; ports `x`, `y`, `bin` -> `d`, `bout`. Instanced once. It is also reusable standalone, mirroring the team's full-adder cell.
- **Top level:** FSM, counter, three shift registers, and the output register.

## Test plan
- **Basic subtraction:** WIDTH=8, `a`=0x5A, `b`=0x23 -> `done` at cycle 9 after `start`, `diff`=0x37, `borrow_out`=0; `busy` high exactly 8 cycles.
- **Wrap-around:** WIDTH=8, `a`=0x00, `b`=0x01 -> `diff`=0xFF, `borrow_out`=1. Then `a`=0xFF, `b`=0xFF -> `diff`=0x00, `borrow_out`=0.
- **Start while busy:** pulse `start` with new operands 3 cycles into SHIFT -> ignored; the original result completes unchanged and no extra `done` follows.
- **Reset mid-operation:** assert `rst` at cycle 4 of SHIFT -> next cycle `busy`=0, `done`=0, `diff`=0, `borrow_out`=0; a following `start` with `a`=10, `b`=3 gives `diff`=7.
- **Back-to-back:** `start` held high through the DONE cycle -> second operation begins with no IDLE gap; `done` pulses at cycles 9 and 18; `diff` holds the first result during the second SHIFT.
- **Exhaustive:** WIDTH=4, all 256 `(a, b)` pairs -> `{borrow_out, diff}` equals the 5-bit value `({1'b0,a} - {1'b0,b})`.
